dpll_ctrl: RTL and testbench
============================

DPLL_CTRL -- requirements
Module: dpll_ctrl

Interface
REQ-001 SHALL have parameter NUM_VARS, default 8: number of Boolean variables searched.
REQ-002 SHALL have parameter CNT_W, default 16: width of the evaluation counter.
REQ-003 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1: begin a search; sampled only in IDLE.
REQ-006 SHALL have port return_true  input  1: all active clauses satisfied under the current partial assignment (from sat_check).
REQ-007 SHALL have port return_false  input  1: some clause falsified under the current partial assignment (from sat_check).
REQ-008 SHALL have port assign_val  output  NUM_VARS: value of each variable; bit i meaningful only when assign_def[i]=1.
REQ-009 SHALL have port assign_def  output  NUM_VARS: bit i set when variable i is assigned.
REQ-010 SHALL have port busy  output  1: high in every state except IDLE.
REQ-011 SHALL have port done  output  1: one-cycle pulse at search end.
REQ-012 SHALL have port sat  output  1: result satisfiable; held until the next accepted start or reset.
REQ-013 SHALL have port unsat  output  1: result unsatisfiable; held likewise.
REQ-014 SHALL have port eval_count  output  CNT_W: number of EVAL cycles in the current search, saturating at all-ones.

Function
REQ-015 SHALL implement FSM states IDLE, EVAL, DECIDE, BACKTRACK, DONE.
REQ-016 SHALL keep an internal depth counter (0..NUM_VARS) and a NUM_VARS-bit flipped vector; variables are decided in index order 0,1,2,...
REQ-017 IDLE with start=1 SHALL clear assign_val, assign_def, flipped, depth, eval_count, sat and unsat, then go to EVAL.
REQ-018 EVAL SHALL increment eval_count (saturating) and sample the inputs with priority return_false > return_true.
REQ-019 EVAL with return_false=1 SHALL go to BACKTRACK, including when return_true=1 in the same cycle.
REQ-020 EVAL with only return_true=1 SHALL set sat and go to DONE.
REQ-021 EVAL with neither input high SHALL go to DECIDE if depth<NUM_VARS; otherwise (all variables assigned) it SHALL treat the cycle as a conflict and go to BACKTRACK.
REQ-022 DECIDE SHALL set assign_def[depth]=1, assign_val[depth]=0 and flipped[depth]=0, increment depth, and go to EVAL.
REQ-023 BACKTRACK with depth=0 SHALL set unsat and go to DONE.
REQ-024 BACKTRACK with flipped[depth-1]=0 SHALL set assign_val[depth-1]=1 and flipped[depth-1]=1, and go to EVAL.
REQ-025 BACKTRACK with flipped[depth-1]=1 SHALL clear assign_def[depth-1] and assign_val[depth-1], decrement depth, and remain in BACKTRACK (one level per cycle).
REQ-026 DONE SHALL assert done for exactly one cycle, then go to IDLE; assignments are held for inspection after sat.
REQ-027 start SHALL be ignored in every state other than IDLE.
REQ-028 return_true and return_false SHALL be used only in EVAL; they are treated as combinational functions of the assignment registered in the previous cycle.
REQ-029 Latency SHALL be: start accepted at edge k gives EVAL during cycle k+1; a decision at EVAL edge m is reached at DONE no earlier than cycle m+1.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE and zero assign_val, assign_def, flipped, depth, eval_count, busy, done, sat and unsat, including mid-search.
REQ-031 rst SHALL take priority over start in the same cycle.

Verification
REQ-032 The bench SHALL cover: return_true=1 constantly, start pulse -> EVAL once, done one cycle later, sat=1, unsat=0, eval_count=1, assign_def=0.
REQ-033 The bench SHALL cover: return_false=1 constantly -> EVAL, BACKTRACK, DONE; unsat=1, eval_count=1, done high for 1 cycle.
REQ-034 The bench SHALL cover: NUM_VARS=2, with a model giving return_true only when assign_def=2'b11 and assign_val=2'b11, and return_false=0 otherwise -> sat=1, assign_val=2'b11, eval_count=7.
REQ-035 The bench SHALL cover: return_true=1 and return_false=1 together on the first EVAL -> treated as conflict; unsat=1 and sat=0.
REQ-036 The bench SHALL cover: rst asserted while in BACKTRACK -> next cycle IDLE with all outputs 0; a subsequent start runs a fresh search with eval_count starting from 0.
REQ-037 The bench SHALL cover: start pulsed while busy=1 -> no effect on state, depth or eval_count.

Source files
------------

// File: rtl/dpll_ctrl.sv
// DPLL search controller: chronological decide/backtrack over NUM_VARS
// variables, driven by sat/conflict verdicts from an external clause checker.
module dpll_ctrl #(
    parameter int NUM_VARS = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                return_true,
    input  logic                return_false,
    output logic [NUM_VARS-1:0] assign_val,
    output logic [NUM_VARS-1:0] assign_def,
    output logic                busy,
    output logic                done,
    output logic                sat,
    output logic                unsat,
    output logic [CNT_W-1:0]    eval_count
);

    localparam int DW = $clog2(NUM_VARS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_DECIDE,
        S_BACK,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_VARS-1:0] val_q, val_d;
    logic [NUM_VARS-1:0] def_q, def_d;
    logic [NUM_VARS-1:0] flip_q, flip_d;
    logic [DW-1:0]       depth_q, depth_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic                unsat_q, unsat_d;

    logic [DW-1:0]       top;
    logic [NUM_VARS-1:0] dec_mask;
    logic [NUM_VARS-1:0] top_mask;
    logic                full;

    // One-hot masks avoid indexing with a depth wider than the variable index
    assign top      = depth_q - DW'(1);
    assign dec_mask = NUM_VARS'(1) << depth_q;
    assign top_mask = NUM_VARS'(1) << top;
    assign full     = (depth_q == DW'(NUM_VARS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            val_q   <= '0;
            def_q   <= '0;
            flip_q  <= '0;
            depth_q <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            unsat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            def_q   <= def_d;
            flip_q  <= flip_d;
            depth_q <= depth_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            unsat_q <= unsat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        def_d   = def_q;
        flip_d  = flip_q;
        depth_d = depth_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        unsat_d = unsat_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    val_d   = '0;
                    def_d   = '0;
                    flip_d  = '0;
                    depth_d = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    unsat_d = 1'b0;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                if (return_false) begin
                    state_d = S_BACK;
                end else if (return_true) begin
                    sat_d   = 1'b1;
                    state_d = S_DONE;
                end else if (!full) begin
                    state_d = S_DECIDE;
                end else begin
                    state_d = S_BACK;
                end
            end
            S_DECIDE: begin
                def_d   = def_q | dec_mask;
                val_d   = val_q & ~dec_mask;
                flip_d  = flip_q & ~dec_mask;
                depth_d = depth_q + DW'(1);
                state_d = S_EVAL;
            end
            S_BACK: begin
                if (depth_q == '0) begin
                    unsat_d = 1'b1;
                    state_d = S_DONE;
                end else if ((flip_q & top_mask) == '0) begin
                    val_d   = val_q | top_mask;
                    flip_d  = flip_q | top_mask;
                    state_d = S_EVAL;
                end else begin
                    def_d   = def_q & ~top_mask;
                    val_d   = val_q & ~top_mask;
                    depth_d = top;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign assign_val = val_q;
    assign assign_def = def_q;
    assign sat        = sat_q;
    assign unsat      = unsat_q;
    assign eval_count = cnt_q;

endmodule

// File: tb/tb_dpll_ctrl.sv
// Bench for dpll_ctrl: a depth-first-search reference model tracks every
// cycle, plus directed literal checks on each scenario's final result.
module tb_dpll_ctrl;

    localparam int NV = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          return_true;
    logic          return_false;
    logic [NV-1:0] assign_val;
    logic [NV-1:0] assign_def;
    logic          busy;
    logic          done;
    logic          sat;
    logic          unsat;
    logic [CW-1:0] eval_count;

    int checks = 0;
    int errors = 0;
    int mode = 0;
    int done_cnt = 0;
    bit armed = 0;

    always #5 clk = ~clk;

    dpll_ctrl #(.NUM_VARS(NV), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .return_true(return_true),
        .return_false(return_false),
        .assign_val(assign_val),
        .assign_def(assign_def),
        .busy(busy),
        .done(done),
        .sat(sat),
        .unsat(unsat),
        .eval_count(eval_count)
    );

    // Clause-checker stand-in: a function of the current assignment
    always_comb begin
        return_true  = 1'b0;
        return_false = 1'b0;
        case (mode)
            0: return_true = 1'b1;
            1: return_false = 1'b1;
            2: return_true = (assign_def == 2'b11) && (assign_val == 2'b11);
            3: begin
                return_true  = 1'b1;
                return_false = 1'b1;
            end
            default: ;
        endcase
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a procedural depth-first search, one clock per step
    logic [NV-1:0] m_val = '0;
    logic [NV-1:0] m_def = '0;
    logic [CW-1:0] m_cnt = '0;
    bit m_busy = 0, m_done = 0, m_sat = 0, m_unsat = 0;
    bit ab = 0;
    bit rt_s, rf_s;

    task automatic m_clear_all();
        m_val = '0; m_def = '0; m_cnt = '0;
        m_busy = 0; m_done = 0; m_sat = 0; m_unsat = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        rt_s = return_true;
        rf_s = return_false;
        if (rst) begin
            m_clear_all();
            ab = 1;
        end
    endtask

    task automatic finish_search();
        m_done = 1;
        tick();
        if (ab) return;
        m_done = 0;
        m_busy = 0;
    endtask

    task automatic run_search();
        int d;
        bit [NV-1:0] fl;
        bit bt;
        d = 0; fl = '0; ab = 0;
        forever begin
            tick();
            if (ab) return;
            if (m_cnt != '1) m_cnt++;
            bt = rf_s || (!rt_s && d == NV);
            if (!bt && rt_s) begin
                m_sat = 1;
                finish_search();
                return;
            end
            if (!bt) begin
                tick();
                if (ab) return;
                m_def[d] = 1; m_val[d] = 0; fl[d] = 0;
                d++;
            end else begin
                forever begin
                    tick();
                    if (ab) return;
                    if (d == 0) begin
                        m_unsat = 1;
                        finish_search();
                        return;
                    end else if (!fl[d-1]) begin
                        m_val[d-1] = 1; fl[d-1] = 1;
                        break;
                    end else begin
                        m_def[d-1] = 0; m_val[d-1] = 0;
                        d--;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_clear_all();
            end else if (start) begin
                m_clear_all();
                m_busy = 1;
                run_search();
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("sat", sat, m_sat);
            chk("unsat", unsat, m_unsat);
            chk("eval_count", eval_count, m_cnt);
            chk("assign_def", assign_def, m_def);
            if (m_sat) chk("assign_val", assign_val, m_val);
            else chk("assign_val_def", assign_val & assign_def, m_val & m_def);
            if (done) done_cnt++;
        end
    end

    task automatic go(int md, bit pulse_busy);
        bit got;
        mode = md;
        done_cnt = 0;
        got = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pulse_busy) start = (i == 1);
            if (done) begin
                got = 1;
                break;
            end
        end
        start = 1'b0;
        chk("done_seen", got, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        armed = 1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", eval_count, 0);
        chk("rst_def", assign_def, 0);
        chk("rst_sat", sat, 0);

        go(0, 0);
        chk("t1_sat", sat, 1);
        chk("t1_unsat", unsat, 0);
        chk("t1_cnt", eval_count, 1);
        chk("t1_def", assign_def, 0);
        @(negedge clk);
        chk("t1_done_cycles", done_cnt, 1);

        go(1, 0);
        chk("t2_unsat", unsat, 1);
        chk("t2_sat", sat, 0);
        chk("t2_cnt", eval_count, 1);
        @(negedge clk);
        chk("t2_done_cycles", done_cnt, 1);

        go(2, 1);
        chk("t3_sat", sat, 1);
        chk("t3_val", assign_val, 2'b11);
        chk("t3_def", assign_def, 2'b11);
        chk("t3_cnt", eval_count, 7);
        @(negedge clk);

        go(3, 0);
        chk("t4_unsat", unsat, 1);
        chk("t4_sat", sat, 0);
        chk("t4_cnt", eval_count, 1);
        @(negedge clk);

        go(4, 0);
        chk("t5_unsat", unsat, 1);
        chk("t5_cnt", eval_count, 7);
        chk("t5_def", assign_def, 0);
        @(negedge clk);

        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t6_busy_bt", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_unsat", unsat, 0);
        chk("t6_sat", sat, 0);
        chk("t6_cnt", eval_count, 0);
        chk("t6_def", assign_def, 0);
        chk("t6_val", assign_val, 0);
        go(0, 0);
        chk("t6_fresh_cnt", eval_count, 1);
        chk("t6_fresh_sat", sat, 1);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
